// File: rtl/ncc_sequencer_pkg.sv
// ncc_pkg: shared types and constants for the NCC search sequencer.
//   state_e    - sequencer FSM states
//   DESC_WORDS - descriptor words per template (tied to the engine's load counters)
//   PATCH_DIM  - window edge length in pixels
//   ENG_IDX_W  - width of the engine window index
//   NCC_W      - width of an NCC score
//   cnt_w()    - counter width for a modulo-n counter, never less than 1 bit
package ncc_pkg;

  localparam int DESC_WORDS = 64;
  localparam int DESC_AW    = $clog2(DESC_WORDS);
  localparam int PATCH_DIM  = 16;
  localparam int ENG_IDX_W  = 9;
  localparam int NCC_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_DESC,
    ST_DRAIN,
    ST_REQ,
    ST_FIRE,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ncc_sequencer_if.sv
// ncc_win_if: window handshake between the sequencer, the patch fetcher and
// the correlation engine's window path.
//   win_req/win_x/win_y    - patch request and origin (sequencer -> fetcher)
//   win_ack                - patch stable on the engine bus (fetcher -> sequencer)
//   window_data_ready      - engine window load strobe (sequencer -> engine)
//   done_with_window_data  - engine finished scoring (engine -> sequencer)
// master: sequencer side; slave: fetcher/engine side.
interface ncc_win_if #(
  parameter int COORD_W = 10
);
  logic               win_req;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
  logic               win_ack;
  logic               window_data_ready;
  logic               done_with_window_data;

  modport master (
    output win_req, win_x, win_y, window_data_ready,
    input  win_ack, done_with_window_data
  );

  modport slave (
    input  win_req, win_x, win_y, window_data_ready,
    output win_ack, done_with_window_data
  );
endinterface

// File: rtl/ncc_sequencer_raster_walker.sv
// raster_walker: column/row counters over the GRID_W x GRID_H origin raster.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - return to origin (0,0)
//   step       - advance one origin in raster order (col first, then row)
//   col, row   - current origin in pixels (counter * STRIDE, zero-extended)
//   last       - current origin is the final one of the raster
module raster_walker
  import ncc_pkg::*;
#(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 10,
  parameter int STRIDE  = 1,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               step,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last
);

  localparam int CW = cnt_w(GRID_W);
  localparam int RW = cnt_w(GRID_H);
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);
  // Counters only change outside REQ, so the scaled origin is stable while
  // a request is outstanding.
  assign col  = COORD_W'(col_q) * COORD_W'(STRIDE);
  assign row  = COORD_W'(row_q) * COORD_W'(STRIDE);

endmodule

// File: rtl/ncc_sequencer.sv
// ncc_sequencer: per-search controller for the 16x16 log-domain NCC engine.
// Clears the engine, streams the template descriptor from SRAM, walks the
// origin raster requesting patches and firing the engine, then captures the
// engine's best score/index.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, abort        - begin search (pulse) / cancel search (level)
//   busy, done          - search in progress / results-valid pulse
//   desc_rd_*           - descriptor SRAM read port (1-cycle read latency)
//   eng_clr             - engine reset
//   desc_data_ready/out - engine descriptor load strobe and word
//   win                 - window handshake (ncc_win_if.master)
//   greatest_ncc/index  - engine running best
//   best_ncc/index      - captured result of the last completed search
module ncc_sequencer
  import ncc_pkg::*;
#(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 10,
  parameter int STRIDE  = 1,
  parameter int COORD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 desc_rd_en,
  output logic [DESC_AW-1:0]   desc_rd_addr,
  input  logic [31:0]          desc_rd_data,
  output logic                 eng_clr,
  output logic                 desc_data_ready,
  output logic [31:0]          desc_data_out,
  ncc_win_if.master            win,
  input  logic [NCC_W-1:0]     greatest_ncc,
  input  logic [ENG_IDX_W-1:0] greatest_index,
  output logic [NCC_W-1:0]     best_ncc,
  output logic [ENG_IDX_W-1:0] best_index
);

  localparam logic [DESC_AW-1:0] ADDR_LAST = DESC_AW'(DESC_WORDS - 1);

  state_e               state_q, state_d;
  logic [DESC_AW-1:0]   addr_q, addr_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 abort_clr_q, abort_clr_d;
  logic                 done_q, done_d;
  logic [NCC_W-1:0]     best_ncc_q, best_ncc_d;
  logic [ENG_IDX_W-1:0] best_idx_q, best_idx_d;

  logic                 walk_clr, walk_step, walk_last;
  logic [COORD_W-1:0]   walk_x, walk_y;
  logic                 win_req_c, wdr_c;

  raster_walker #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .STRIDE  (STRIDE),
    .COORD_W (COORD_W)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (walk_clr),
    .step  (walk_step),
    .col   (walk_x),
    .row   (walk_y),
    .last  (walk_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    abort_clr_d = 1'b0;
    done_d      = 1'b0;
    best_ncc_d  = best_ncc_q;
    best_idx_d  = best_idx_q;
    desc_rd_en  = 1'b0;
    win_req_c   = 1'b0;
    wdr_c       = 1'b0;
    walk_clr    = 1'b0;
    walk_step   = 1'b0;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR: begin
        addr_d   = '0;
        walk_clr = 1'b1;
        state_d  = ST_DESC;
      end
      ST_DESC: begin
        desc_rd_en = 1'b1;
        addr_d     = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
      end
      // The final SRAM word is still in flight; it is loaded here.
      ST_DRAIN: state_d = ST_REQ;
      ST_REQ: begin
        win_req_c = 1'b1;
        if (win.win_ack) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        wdr_c   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (win.done_with_window_data) begin
          walk_step = 1'b1;
          state_d   = walk_last ? ST_CAPTURE : ST_REQ;
        end
      end
      ST_CAPTURE: begin
        best_ncc_d = greatest_ncc;
        best_idx_d = greatest_index;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition, including a coincident win_ack.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      abort_clr_d = 1'b1;
      walk_step   = 1'b0;
      done_d      = 1'b0;
      best_ncc_d  = best_ncc_q;
      best_idx_d  = best_idx_q;
    end
  end

  // A read issued in the abort cycle is not loaded into the engine.
  assign rd_vld_d = desc_rd_en && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      abort_clr_q <= 1'b0;
      done_q      <= 1'b0;
      best_ncc_q  <= '0;
      best_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      abort_clr_q <= abort_clr_d;
      done_q      <= done_d;
      best_ncc_q  <= best_ncc_d;
      best_idx_q  <= best_idx_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign desc_rd_addr    = addr_q;
  // Engine is held in reset alongside the sequencer.
  assign eng_clr         = !rst_n || (state_q == ST_CLR) || abort_clr_q;
  assign desc_data_ready = rd_vld_q;
  assign desc_data_out   = desc_rd_data;
  assign best_ncc        = best_ncc_q;
  assign best_index      = best_idx_q;

  assign win.win_req           = win_req_c;
  assign win.win_x             = walk_x;
  assign win.win_y             = walk_y;
  assign win.window_data_ready = wdr_c;

endmodule

// File: tb/tb_ncc_sequencer.sv
// Directed bench for ncc_sequencer on a 3x2 raster, stride 4, with SRAM,
// patch-fetcher and engine models.
module tb_ncc_sequencer;
  import ncc_pkg::*;

  localparam int GW = 3, GH = 2, ST = 4, CWD = 10;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        busy, done, desc_rd_en, eng_clr, desc_data_ready;
  logic [5:0]  desc_rd_addr;
  logic [31:0] desc_rd_data, desc_data_out;
  logic [31:0] greatest_ncc, best_ncc;
  logic [8:0]  greatest_index, best_index;

  always #5 clk = ~clk;

  ncc_win_if #(.COORD_W(CWD)) wif ();

  ncc_sequencer #(.GRID_W(GW), .GRID_H(GH), .STRIDE(ST), .COORD_W(CWD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .desc_rd_en      (desc_rd_en),
    .desc_rd_addr    (desc_rd_addr),
    .desc_rd_data    (desc_rd_data),
    .eng_clr         (eng_clr),
    .desc_data_ready (desc_data_ready),
    .desc_data_out   (desc_data_out),
    .win             (wif),
    .greatest_ncc    (greatest_ncc),
    .greatest_index  (greatest_index),
    .best_ncc        (best_ncc),
    .best_index      (best_index)
  );

  // Descriptor SRAM: word i = A0000000 + i, one-cycle read latency.
  always @(posedge clk)
    if (desc_rd_en) desc_rd_data <= 32'hA000_0000 + {26'd0, desc_rd_addr};

  // Patch fetcher: ack 2 cycles after req (30 for window stall_idx), held until req drops.
  int f_cnt = 0, f_win = 0, stall_idx = 99;
  always @(posedge clk) begin
    if (eng_clr) begin
      wif.win_ack <= 1'b0; f_cnt <= 0; f_win <= 0;
    end else if (!wif.win_req) begin
      wif.win_ack <= 1'b0; f_cnt <= 0;
    end else if (!wif.win_ack) begin
      f_cnt <= f_cnt + 1;
      if (f_cnt + 1 >= ((f_win == stall_idx) ? 30 : 2)) begin
        wif.win_ack <= 1'b1; f_win <= f_win + 1;
      end
    end
  end

  // Engine model: scores window k as scores[k], keeps first maximum.
  logic [31:0] scores [0:5];
  int e_widx = 0;
  always @(posedge clk) begin
    if (eng_clr) begin
      wif.done_with_window_data <= 1'b0;
      greatest_ncc <= '0; greatest_index <= '0; e_widx <= 0;
    end else begin
      wif.done_with_window_data <= wif.window_data_ready;
      if (wif.window_data_ready && e_widx < 6) begin
        if (scores[e_widx] > greatest_ncc) begin
          greatest_ncc   <= scores[e_widx];
          greatest_index <= 9'(e_widx);
        end
        e_widx <= e_widx + 1;
      end
    end
  end

  // Monitors.
  int rdy_cnt = 0, word_err = 0, d_idx = 0, clr_cnt = 0, done_cnt = 0;
  int stab_err = 0, bad_wdr = 0, req_total = 0;
  logic [19:0] req_log [0:63];
  logic        prev_req = 1'b0, acked = 1'b0;
  logic [9:0]  px = '0, py = '0;
  always @(posedge clk) begin
    if (eng_clr) d_idx <= 0;
    else if (desc_data_ready) begin
      rdy_cnt <= rdy_cnt + 1;
      if (desc_data_out !== 32'hA000_0000 + 32'(d_idx)) word_err <= word_err + 1;
      d_idx <= d_idx + 1;
    end
    if (eng_clr && rst_n) clr_cnt <= clr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (wif.win_req && prev_req && (wif.win_x !== px || wif.win_y !== py))
      stab_err <= stab_err + 1;
    prev_req <= wif.win_req;
    px <= wif.win_x;
    py <= wif.win_y;
    if (wif.win_req && wif.win_ack) begin
      req_log[req_total[5:0]] <= {wif.win_x, wif.win_y};
      req_total <= req_total + 1;
      acked <= 1'b1;
    end
    if (wif.window_data_ready) begin
      if (!acked) bad_wdr <= bad_wdr + 1;
      acked <= 1'b0;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a search and runs until done; optionally pulses start at DESC
  // address 10 and in the first WAIT cycle. lat = cycles from start edge to done.
  task automatic do_search(input bit inject, output int lat, output int first_rdy);
    int  n;
    bit  inj_wait, prev_wdr;
    n = 0; lat = -1; first_rdy = -1; inj_wait = 0; prev_wdr = 0;
    start = 1'b1;
    while (n < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (desc_data_ready && first_rdy < 0) first_rdy = n;
      if (done) begin lat = n; break; end
      if (inject) begin
        if (desc_rd_en && desc_rd_addr == 6'd10) start = 1'b1;
        if (prev_wdr && !inj_wait) begin start = 1'b1; inj_wait = 1; end
      end
      prev_wdr = wif.window_data_ready;
    end
  endtask

  logic [19:0] exp_req [0:5];
  int n, k, lat, fr, b_rdy, b_werr, b_done, b_req, b_clr, b_stab, b_bad;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_req = '{{10'd0, 10'd0}, {10'd4, 10'd0}, {10'd8, 10'd0},
                {10'd0, 10'd4}, {10'd4, 10'd4}, {10'd8, 10'd4}};
    scores  = '{32'd10, 32'd50, 32'd20, 32'd50, 32'd5, 32'd7};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_strobes", {desc_rd_en, desc_data_ready, wif.win_req, wif.window_data_ready, done, busy}, 6'b0);
    check("rst_eng_clr", eng_clr, 1'b1);
    check("rst_best", {best_ncc, best_index}, 41'd0);
    check("rst_addr", desc_rd_addr, 6'd0);
    check("rst_coord", {wif.win_x, wif.win_y}, 20'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_eng_clr", eng_clr, 1'b0);

    // Reset in the middle of the descriptor stream
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clr_pulse", eng_clr, 1'b1);
    check("busy_after_start", busy, 1'b1);
    n = 0;
    while (!(desc_rd_en && desc_rd_addr == 6'd20) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("cycles_to_addr20", n, 21);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_eng_clr", eng_clr, 1'b1);
    check("async_rst_rd", {desc_rd_en, desc_rd_addr}, 7'd0);
    @(posedge clk); #1;
    check("rst_hold_strobes", {desc_rd_en, desc_data_ready, wif.win_req, done, busy, eng_clr}, 6'b000001);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Descriptor stream + full raster
    b_rdy = rdy_cnt; b_werr = word_err; b_done = done_cnt; b_req = req_total;
    do_search(1'b0, lat, fr);
    check("s1_busy_at_done", busy, 1'b0);
    check("s1_first_ready", fr, 3);
    check("s1_latency", lat, 98);
    @(posedge clk); #1;
    check("s1_done_width", done, 1'b0);
    check("s1_ready_count", rdy_cnt - b_rdy, 64);
    check("s1_word_errors", word_err - b_werr, 0);
    check("s1_done_count", done_cnt - b_done, 1);
    check("s1_best_ncc", best_ncc, 32'd50);
    check("s1_best_index", best_index, 9'd1);
    check("s1_req_count", req_total - b_req, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("s1_req%0d", i), req_log[b_req + i], exp_req[i]);

    // Stalled ack on window 2
    stall_idx = 2;
    b_done = done_cnt; b_stab = stab_err; b_bad = bad_wdr; b_req = req_total;
    do_search(1'b0, lat, fr);
    stall_idx = 99;
    check("s2_latency", lat, 126);
    check("s2_coord_unstable", stab_err - b_stab, 0);
    check("s2_early_fire", bad_wdr - b_bad, 0);
    check("s2_req2", req_log[b_req + 2], exp_req[2]);
    @(posedge clk); #1;
    check("s2_done_count", done_cnt - b_done, 1);
    check("s2_best", {best_ncc, best_index}, {32'd50, 9'd1});

    // Abort in WAIT of window 3
    scores = '{32'd99, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    b_done = done_cnt; b_clr = clr_cnt; b_req = req_total;
    start = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 500) begin
      @(posedge clk); #1;
      start = 1'b0; n++;
      if (wif.window_data_ready) k++;
    end
    check("s3_reach_fire3", k, 4);
    @(posedge clk); #1;
    check("s3_engine_done_in_wait", wif.done_with_window_data, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("s3_abort_busy", busy, 1'b0);
    check("s3_abort_eng_clr", eng_clr, 1'b1);
    check("s3_abort_req", wif.win_req, 1'b0);
    @(posedge clk); #1;
    check("s3_eng_clr_end", eng_clr, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("s3_clr_pulses", clr_cnt - b_clr, 2);
    check("s3_no_done", done_cnt - b_done, 0);
    check("s3_best_kept", {best_ncc, best_index}, {32'd50, 9'd1});
    check("s3_req_count", req_total - b_req, 4);

    // Fresh search after abort, with start pulses while busy
    scores = '{32'd3, 32'd8, 32'd8, 32'd1, 32'd9, 32'd2};
    b_rdy = rdy_cnt; b_werr = word_err; b_done = done_cnt; b_req = req_total;
    do_search(1'b1, lat, fr);
    check("s4_latency", lat, 98);
    check("s4_first_ready", fr, 3);
    repeat (4) @(posedge clk);
    #1;
    check("s4_idle", busy, 1'b0);
    check("s4_done_count", done_cnt - b_done, 1);
    check("s4_ready_count", rdy_cnt - b_rdy, 64);
    check("s4_word_errors", word_err - b_werr, 0);
    check("s4_req_count", req_total - b_req, 6);
    check("s4_req5", req_log[b_req + 5], exp_req[5]);
    check("s4_best", {best_ncc, best_index}, {32'd9, 9'd4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
